// File: rtl/mips_alu_32b.sv
// ---------------------------------------------------------------------------
// mips_alu_32b
//
// MIPS-style integer execute stage. A small ALU-control decoder turns the
// main-decoder op class (ALUOp) and, for R-type instructions, the funct
// field into a 4-bit operation code. A 32-bit ALU then computes the result
// and the signed-overflow flag. All outputs are registered, so the latency
// is one cycle and a new operation is accepted on every clock edge.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset (release synchronised
//                        to clk outside this block)
//   ALUOp       in   2   00/11 add, 01 subtract, 10 decode funct
//   funct       in   6   R-type funct field, only used when ALUOp = 10
//   A           in  32   operand A (rs)
//   B           in  32   operand B (rt or sign-extended immediate)
//   ALUControl  out  4   registered decoded operation code
//   Result      out 32   registered ALU result
//   Overflow    out  1   registered two's-complement overflow (add/sub only)
//   Zero        out  1   registered (Result == 0)
// ---------------------------------------------------------------------------
module mips_alu_32b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ALUOp,
    input  logic [5:0]  funct,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [3:0]  ALUControl,
    output logic [31:0] Result,
    output logic        Overflow,
    output logic        Zero
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100,
        OP_INV = 4'b1111
    } alu_ctrl_e;

    alu_ctrl_e   ctrl_d,     ctrl_q;
    logic [31:0] result_d,   result_q;
    logic        overflow_d, overflow_q;
    logic        zero_d,     zero_q;

    logic [31:0] sum;
    logic [31:0] diff;
    logic        add_ovf;
    logic        sub_ovf;

    // ------------------------------------------------------------------
    // ALU-control decode
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ctrl_d = OP_INV;
        unique case (ALUOp)
            2'b00, 2'b11: ctrl_d = OP_ADD;
            2'b01:        ctrl_d = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: ctrl_d = OP_ADD;
                    6'b100010: ctrl_d = OP_SUB;
                    6'b100100: ctrl_d = OP_AND;
                    6'b100101: ctrl_d = OP_OR;
                    6'b100111: ctrl_d = OP_NOR;
                    6'b101010: ctrl_d = OP_SLT;
                    default:   ctrl_d = OP_INV;
                endcase
            end
            default:      ctrl_d = OP_INV;
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic datapath
    // ------------------------------------------------------------------
    assign sum  = A + B;
    assign diff = A + ~B + 32'd1;

    // Add overflows when both operands share a sign the result lacks; sub
    // overflows when operand signs differ and the result's sign leaves A's.
    assign add_ovf = (A[31] == B[31]) && (sum[31]  != A[31]);
    assign sub_ovf = (A[31] != B[31]) && (diff[31] != A[31]);

    always_comb begin
        result_d   = 32'd0;
        overflow_d = 1'b0;
        case (ctrl_d)
            OP_AND: result_d = A & B;
            OP_OR:  result_d = A | B;
            OP_NOR: result_d = ~(A | B);
            OP_ADD: begin
                result_d   = sum;
                overflow_d = add_ovf;
            end
            OP_SUB: begin
                result_d   = diff;
                overflow_d = sub_ovf;
            end
            // The sign of A-B is wrong exactly when the subtraction
            // overflows, so XOR-ing the two gives the true signed compare.
            // The flag itself stays 0 for slt.
            OP_SLT:  result_d = {31'd0, diff[31] ^ sub_ovf};
            default: result_d = 32'd0;
        endcase
    end

    assign zero_d = (result_d == 32'd0);

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all four
    // registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= OP_AND;
            result_q   <= 32'd0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign ALUControl = ctrl_q;
    assign Result     = result_q;
    assign Overflow   = overflow_q;
    assign Zero       = zero_q;

endmodule

// File: tb/tb_mips_alu_32b.sv
// ---------------------------------------------------------------------------
// tb_mips_alu_32b
//
// Scoreboard bench for mips_alu_32b. The driver applies one operation per
// cycle on the falling edge and queues the expected response; the monitor
// pops one entry per rising edge taken with reset high and compares it to
// the registered outputs. Directed vectors carry hand-derived expectations;
// random vectors are scored against a reference model that works on signed
// integers rather than on bit-level adder equations.
// ---------------------------------------------------------------------------
module tb_mips_alu_32b;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ALUOp;
    logic [5:0]  funct;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUControl;
    logic [31:0] Result;
    logic        Overflow;
    logic        Zero;

    mips_alu_32b dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUOp      (ALUOp),
        .funct      (funct),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Result     (Result),
        .Overflow   (Overflow),
        .Zero       (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] result;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] result;
        logic        ovf;
        logic        zero;
    } vec_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: operation chosen from the instruction fields, value
    // computed with wide signed arithmetic, overflow = result out of range.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.name = "rand";
        e.ovf  = 1'b0;
        if (op == 2'b01)
            e.ctrl = 4'b0110;
        else if (op != 2'b10)
            e.ctrl = 4'b0010;
        else if (fn == 6'h20) e.ctrl = 4'b0010;
        else if (fn == 6'h22) e.ctrl = 4'b0110;
        else if (fn == 6'h24) e.ctrl = 4'b0000;
        else if (fn == 6'h25) e.ctrl = 4'b0001;
        else if (fn == 6'h27) e.ctrl = 4'b1100;
        else if (fn == 6'h2A) e.ctrl = 4'b0111;
        else                  e.ctrl = 4'b1111;
        case (e.ctrl)
            4'b0010, 4'b0110: begin
                r = (e.ctrl == 4'b0010) ? sa + sb : sa - sb;
                e.result = r[31:0];
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'b0000: e.result = a & b;
            4'b0001: e.result = a | b;
            4'b1100: e.result = ~(a | b);
            4'b0111: e.result = (sa < sb) ? 32'd1 : 32'd0;
            default: e.result = 32'd0;
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUOp = op;
        funct = fn;
        A     = a;
        B     = b;
    endtask

    task automatic issue_vec(input vec_t v);
        exp_t e;
        drive(v.op, v.fn, v.a, v.b);
        e.name = v.name; e.ctrl = v.ctrl; e.result = v.result;
        e.ovf  = v.ovf;  e.zero = v.zero;
        sb_q.push_back(e);
    endtask

    task automatic issue_rand(input logic [1:0] op, input logic [5:0] fn,
                              input logic [31:0] a, input logic [31:0] b);
        drive(op, fn, a, b);
        sb_q.push_back(model(op, fn, a, b));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, ".ctrl"},   {28'd0, ALUControl}, 32'd0);
        check({tag, ".result"}, Result,              32'd0);
        check({tag, ".ovf"},    {31'd0, Overflow},   32'd0);
        check({tag, ".zero"},   {31'd0, Zero},       32'd0);
    endtask

    // Monitor: each rising edge taken with reset high presents one result.
    initial begin
        logic rst_at_edge;
        exp_t e;
        forever begin
            @(posedge clk);
            rst_at_edge = rst_n;
            #1;
            if (rst_at_edge && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".ctrl"},   {28'd0, ALUControl}, {28'd0, e.ctrl});
                check({e.name, ".result"}, Result,              e.result);
                check({e.name, ".ovf"},    {31'd0, Overflow},   {31'd0, e.ovf});
                check({e.name, ".zero"},   {31'd0, Zero},       {31'd0, e.zero});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        dir[$];
        vec_t        v;
        logic [5:0]  fn_tab [6];
        exp_t        e;
        int          drain;

        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

        dir.push_back('{"beq_eq",     2'b01, 6'h00, 32'd5,          32'd5,          4'b0110, 32'h0000_0000, 1'b0, 1'b1});
        dir.push_back('{"beq_ne",     2'b01, 6'h00, 32'd5,          32'd6,          4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0});
        dir.push_back('{"add_ovf",    2'b10, 6'h20, 32'h7FFF_FFFF,  32'd1,          4'b0010, 32'h8000_0000, 1'b1, 1'b0});
        dir.push_back('{"sub_ovf",    2'b01, 6'h00, 32'h8000_0000,  32'd1,          4'b0110, 32'h7FFF_FFFF, 1'b1, 1'b0});
        dir.push_back('{"add_wrap0",  2'b00, 6'h00, 32'hFFFF_FFFF,  32'd1,          4'b0010, 32'h0000_0000, 1'b0, 1'b1});
        dir.push_back('{"slt_neg",    2'b10, 6'h2A, 32'h8000_0000,  32'd1,          4'b0111, 32'h0000_0001, 1'b0, 1'b0});
        dir.push_back('{"slt_pos",    2'b10, 6'h2A, 32'd1,          32'h8000_0000,  4'b0111, 32'h0000_0000, 1'b0, 1'b1});
        dir.push_back('{"slt_ovf",    2'b10, 6'h2A, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  4'b0111, 32'h0000_0000, 1'b0, 1'b1});
        dir.push_back('{"and",        2'b10, 6'h24, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'b0000, 32'h00F0_00F0, 1'b0, 1'b0});
        dir.push_back('{"or",         2'b10, 6'h25, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'b0001, 32'hFFF0_FFF0, 1'b0, 1'b0});
        dir.push_back('{"nor",        2'b10, 6'h27, 32'd0,          32'd0,          4'b1100, 32'hFFFF_FFFF, 1'b0, 1'b0});
        dir.push_back('{"invalid",    2'b10, 6'h00, 32'd1,          32'd2,          4'b1111, 32'h0000_0000, 1'b0, 1'b1});
        dir.push_back('{"aluop11",    2'b11, 6'h22, 32'd3,          32'd4,          4'b0010, 32'h0000_0007, 1'b0, 1'b0});

        // Reset state, checked asynchronously before any clock edge.
        rst_n = 1'b0;
        ALUOp = 2'b00; funct = 6'h00; A = 32'd0; B = 32'd0;
        #1;
        check_outputs_zero("reset_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (dir[i]) issue_vec(dir[i]);

        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            logic [5:0] fn;
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
            else                           fn = fn_tab[$urandom_range(0, 5)];
            issue_rand(op, fn, pick_operand(), pick_operand());
        end

        // Reset in the middle of a stream.
        v = '{"pre_reset_sub", 2'b01, 6'h00, 32'd3, 32'd5, 4'b0110, 32'hFFFF_FFFE, 1'b0, 1'b0};
        issue_vec(v);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_async");
        ALUOp = 2'b00; funct = 6'h00; A = 32'd10; B = 32'd20;
        @(posedge clk);
        #1;
        check_outputs_zero("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        e.name = "post_reset"; e.ctrl = 4'b0010; e.result = 32'd30; e.ovf = 1'b0; e.zero = 1'b0;
        sb_q.push_back(e);

        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        if (sb_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
